stall_unit: RTL and testbench
=============================

# stall_unit

Hazard-detection block for the 5-stage MIPS pipeline (F/D/E/M/W). It compares the instruction in decode against the instructions in E and M using a Tuse/Tnew model. It also checks the multiply/divide unit's busy state and a CP0 `eret`/EPC hazard. It drives a single `Stall` signal that freezes PC and the F/D register and injects a bubble into D/E; all forwardable cases pass without stalling.

## Interface
- No parameters.
- `clk` input 1: pipeline clock; present for uniformity, no internal state.
- `reset` input 1: synchronous, active-high pipeline reset; forces `Stall`=0 while high.
- `FD_IR` input 32: instruction in D (F/D register).
- `DE_IR` input 32: instruction in E (D/E register).
- `EM_IR` input 32: instruction in M (E/M register).
- `MW_IR` input 32: instruction in W; not used by any stall term.
- `E_Busy` input 1: mult/div unit busy.
- `E_Start` input 2: nonzero = mult/div start issued in E this cycle.
- `Stall` output 1: 1 = freeze PC and F/D, bubble D/E.

## Operation
- Fully combinational: `Stall` = !reset & (stall_rs | stall_rt | stall_md | stall_eret).
- Decode fields: rs=[25:21], rt=[20:16], rd=[15:11]. An all-zero IR is a nop: no sources, no destination.
- **Tuse in D (sources of FD_IR):**
  - 0 for rs, rt of beq/bne; rs of blez/bgtz/bltz/bgez, jr, jalr.
  - 1 for rs,rt of R-type ALU (add/addu/sub/subu/and/or/xor/nor/slt/sltu/sllv/srlv/srav), rt of sll/srl/sra, rs,rt of mult/multu/div/divu.
  - 1 for rs of I-type ALU (addi/addiu/andi/ori/xori/slti/sltiu), rs of mthi/mtlo, and the base rs of every load/store.
  - 2 for store data rt (sb/sh/sw) and mtc0 rt.
  - Instructions with no source register declare none.
- **Destination:**
  - rd for R-type ALU, mfhi/mflo and jalr.
  - rt for I-type ALU, lui, loads and mfc0.
  - $31 for jal.
  - Destination $0 never causes a stall.
- **Tnew by stage:**
  - In E: 2 for loads (lb/lbu/lh/lhu/lw) and mfc0; 1 for R-type ALU, I-type ALU, lui, mfhi, mflo; 0 for jal/jalr.
  - In M: 1 for loads and mfc0; 0 otherwise.
  - In W: always 0.
- stall_rs/stall_rt: the source is used, equals a nonzero destination of DE_IR or EM_IR, and Tuse < Tnew of that stage.
- stall_md: FD_IR is mult/multu/div/divu/mfhi/mflo/mthi/mtlo and (E_Busy | E_Start≠0).
- stall_eret: FD_IR is eret and (DE_IR or EM_IR is mtc0 with rd=14, EPC).

## Timing
- Zero-cycle latency; `Stall` settles within the same cycle as its inputs change.
- No handshake. The pipeline re-evaluates every cycle, so a load-use hazard in E costs 1 or 2 cycles depending on Tuse.
- `reset`=1 → `Stall`=0 regardless of IRs, so the reset edge is never blocked.
- Boundaries:
  - Simultaneous E and M hazards: OR.
  - An equal Tuse and Tnew never stalls, because forwarding covers it.
  - `E_Busy` glitches shorter than a cycle have no registered effect.

## Test plan
- Load-use from E:
  - DE=8c410000 (lw $1), FD=00221022 (sub uses $1) → Stall=1.
  - DE=90410000 (lbu $1), FD=ac010000 (sw data $1) → Stall=0.
- Branch/jump vs ALU in E:
  - DE=00430821 (addu $1), FD=10220019 (beq $1,$2) → 1.
  - DE=3c01000f (lui $1), FD=00200008 (jr $1) → 1.
  - DE=00620807 (srav $1), FD=0020f809 (jalr $1) → 1.
- Load in M vs branch: EM=90210000 (lbu $1), DE=0, FD=1422000c (bne $1,$2) → 1. Same EM with FD=00221022 → 0.
- Mult/div:
  - FD=00001810 (mfhi) with E_Busy=1 → 1.
  - FD=00600013 (mtlo) with DE=0022001a (div) and E_Start=2'b01 → 1.
  - FD=00001012 (mflo) with Busy=0 and Start=0 → 0.
- $0 and reset:
  - DE=8c000000 (lw $0), FD=00001021 → 0.
  - reset=1 with DE=8c410000, FD=00221022 → 0.
- eret: DE=40817000 (mtc0 $1, EPC), FD=42000018 → 1.

Source files
------------

// File: rtl/stall_unit_if.sv
// Pipeline-register view seen by the hazard unit: the four stage
// instructions, the mult/div status from E, and the resulting stall.
interface stall_unit_if;
    logic [31:0] FD_IR;
    logic [31:0] DE_IR;
    logic [31:0] EM_IR;
    logic [31:0] MW_IR;
    logic        E_Busy;
    logic [1:0]  E_Start;
    logic        Stall;

    // Pipeline datapath side: supplies instructions and status, consumes Stall.
    modport master (
        output FD_IR, DE_IR, EM_IR, MW_IR, E_Busy, E_Start,
        input  Stall
    );

    // Hazard unit side.
    modport slave (
        input  FD_IR, DE_IR, EM_IR, MW_IR, E_Busy, E_Start,
        output Stall
    );
endinterface

// File: rtl/stall_unit.sv
// Hazard detection for the 5-stage MIPS pipeline. Compares the source
// registers of the instruction in D against the destinations of the
// instructions in E and M using a Tuse/Tnew model. Also handles mult/div
// busy and the eret-after-mtc0-EPC hazard. Purely combinational.
module stall_unit (
    input  logic         clk,
    input  logic         reset,
    stall_unit_if.slave  bus
);

    // Decoded hazard attributes of one instruction.
    typedef struct packed {
        logic       rs_used;
        logic [1:0] rs_tuse;
        logic       rt_used;
        logic [1:0] rt_tuse;
        logic [4:0] dst;         // 0 means no destination
        logic [1:0] tnew_e;      // cycles until result is forwardable, in E
        logic [1:0] tnew_m;      // same, in M
        logic       is_md;       // touches the mult/div unit
        logic       is_eret;
        logic       is_mtc0_epc; // mtc0 writing EPC (cp0 reg 14)
    } dec_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_COP0   = 6'h10;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;
    localparam logic [5:0] FN_ERET  = 6'h18;

    localparam logic [4:0] CP0_MFC0 = 5'h00;
    localparam logic [4:0] CP0_MTC0 = 5'h04;
    localparam logic [4:0] CP0_EPC  = 5'd14;

    // Translate one instruction word into its hazard attributes.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        op = ir[31:26];
        fn = ir[5:0];
        rs = ir[25:21];
        rt = ir[20:16];
        rd = ir[15:11];
        d  = '0;
        // An all-zero word is a nop: no sources, no destination.
        if (ir != 32'd0) begin
            case (op)
                OP_RTYPE: begin
                    case (fn)
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
                        FN_SLLV, FN_SRLV, FN_SRAV: begin
                            d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                            d.rt_used = 1'b1; d.rt_tuse = 2'd1;
                            d.dst     = rd;   d.tnew_e  = 2'd1;
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            d.rt_used = 1'b1; d.rt_tuse = 2'd1;
                            d.dst     = rd;   d.tnew_e  = 2'd1;
                        end
                        FN_JR: begin
                            d.rs_used = 1'b1; d.rs_tuse = 2'd0;
                        end
                        FN_JALR: begin
                            d.rs_used = 1'b1; d.rs_tuse = 2'd0;
                            d.dst     = rd;   d.tnew_e  = 2'd0;
                        end
                        FN_MFHI, FN_MFLO: begin
                            d.dst   = rd; d.tnew_e = 2'd1;
                            d.is_md = 1'b1;
                        end
                        FN_MTHI, FN_MTLO: begin
                            d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                            d.is_md   = 1'b1;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                            d.rt_used = 1'b1; d.rt_tuse = 2'd1;
                            d.is_md   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_BEQ, OP_BNE: begin
                    d.rs_used = 1'b1; d.rs_tuse = 2'd0;
                    d.rt_used = 1'b1; d.rt_tuse = 2'd0;
                end
                OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                    d.rs_used = 1'b1; d.rs_tuse = 2'd0;
                end
                OP_JAL: begin
                    d.dst = 5'd31; d.tnew_e = 2'd0;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI: begin
                    d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                    d.dst     = rt;   d.tnew_e  = 2'd1;
                end
                OP_LUI: begin
                    d.dst = rt; d.tnew_e = 2'd1;
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                    d.dst     = rt;
                    d.tnew_e  = 2'd2; d.tnew_m  = 2'd1;
                end
                OP_SB, OP_SH, OP_SW: begin
                    d.rs_used = 1'b1; d.rs_tuse = 2'd1;
                    d.rt_used = 1'b1; d.rt_tuse = 2'd2;
                end
                OP_COP0: begin
                    if (ir[25] && fn == FN_ERET) begin
                        d.is_eret = 1'b1;
                    end else if (rs == CP0_MFC0) begin
                        d.dst    = rt;
                        d.tnew_e = 2'd2; d.tnew_m = 2'd1;
                    end else if (rs == CP0_MTC0) begin
                        d.rt_used     = 1'b1; d.rt_tuse = 2'd2;
                        d.is_mtc0_epc = (rd == CP0_EPC);
                    end
                end
                default: ;
            endcase
        end
        return d;
    endfunction

    // One source against one producer: stall only if the value cannot be
    // forwarded in time. Equal Tuse and Tnew is covered by forwarding.
    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return used && (dst != 5'd0) && (src == dst) && (tuse < tnew);
    endfunction

    dec_t fd_dec;
    dec_t de_dec;
    dec_t em_dec;
    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_eret;

    assign fd_dec = decode(bus.FD_IR);
    assign de_dec = decode(bus.DE_IR);
    assign em_dec = decode(bus.EM_IR);

    // Combine the four hazard sources into the stall terms.
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no
        // path through the conditions below can leave a latch behind.
        stall_rs   = 1'b0;
        stall_rt   = 1'b0;
        stall_md   = 1'b0;
        stall_eret = 1'b0;

        stall_rs = src_hazard(fd_dec.rs_used, bus.FD_IR[25:21], fd_dec.rs_tuse,
                              de_dec.dst, de_dec.tnew_e)
                 | src_hazard(fd_dec.rs_used, bus.FD_IR[25:21], fd_dec.rs_tuse,
                              em_dec.dst, em_dec.tnew_m);

        stall_rt = src_hazard(fd_dec.rt_used, bus.FD_IR[20:16], fd_dec.rt_tuse,
                              de_dec.dst, de_dec.tnew_e)
                 | src_hazard(fd_dec.rt_used, bus.FD_IR[20:16], fd_dec.rt_tuse,
                              em_dec.dst, em_dec.tnew_m);

        if (fd_dec.is_md && (bus.E_Busy || bus.E_Start != 2'b00)) begin
            stall_md = 1'b1;
        end

        if (fd_dec.is_eret && (de_dec.is_mtc0_epc || em_dec.is_mtc0_epc)) begin
            stall_eret = 1'b1;
        end
    end

    // Reset gates the stall in the same cycle so the reset edge is never held off.
    assign bus.Stall = !reset && (stall_rs || stall_rt || stall_md || stall_eret);

    // clk and the W-stage instruction take no part in any stall term; neither
    // do some decoded fields of the E/M/D views. They are folded into a sink.
    logic unused_sink;
    assign unused_sink = ^{clk, bus.MW_IR, fd_dec, de_dec, em_dec};

endmodule

// File: tb/tb_stall_unit.sv
// Self-checking bench for stall_unit. Each scenario task drives instruction
// vectors, pushes the expected Stall into a scoreboard queue, and pops and
// compares it once the combinational output has settled.
module tb_stall_unit;

    logic clk;
    logic reset;

    stall_unit_if bus ();

    stall_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] fd;
        logic [31:0] de;
        logic [31:0] em;
        logic        busy;
        logic [1:0]  start;
        logic        exp;
    } vec_t;

    typedef struct {
        string name;
        logic  exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string name, input logic rst,
                                input logic [31:0] fd, input logic [31:0] de,
                                input logic [31:0] em, input logic busy,
                                input logic [1:0] start, input logic exp);
        vec_t v;
        v.name = name; v.rst = rst; v.fd = fd; v.de = de; v.em = em;
        v.busy = busy; v.start = start; v.exp = exp;
        return v;
    endfunction

    // Apply a vector just after a rising edge and record its expected stall.
    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = v.rst;
        bus.FD_IR   = v.fd;
        bus.DE_IR   = v.de;
        bus.EM_IR   = v.em;
        bus.MW_IR   = 32'h8c1f0000;
        bus.E_Busy  = v.busy;
        bus.E_Start = v.start;
        e.name = v.name;
        e.exp  = v.exp;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("reset_idle",    1'b1, 32'h0,        32'h0,        32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("reset_loaduse", 1'b1, 32'h00221022, 32'h8c410000, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("reset_md",      1'b1, 32'h00001810, 32'h0,        32'h0, 1'b1, 2'b01, 1'b0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("lw_E_sub",      1'b0, 32'h00221022, 32'h8c410000, 32'h0, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("lbu_E_swdata",  1'b0, 32'hac010000, 32'h90410000, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("lw_E_swbase",   1'b0, 32'hac220000, 32'h8c410000, 32'h0, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("lw0_E",         1'b0, 32'h00001021, 32'h8c000000, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("nop_D",         1'b0, 32'h0,        32'h8c410000, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("mfc0_E_add",    1'b0, 32'h00221020, 32'h40016000, 32'h0, 1'b0, 2'b00, 1'b1));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    task automatic test_branch_alu();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("addu_E_beq",   1'b0, 32'h10220019, 32'h00430821, 32'h0, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("lui_E_jr",     1'b0, 32'h00200008, 32'h3c01000f, 32'h0, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("srav_E_jalr",  1'b0, 32'h0020f809, 32'h00620807, 32'h0, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("addu_E_sub",   1'b0, 32'h00221022, 32'h00430821, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("jal_E_jr31",   1'b0, 32'h03e00008, 32'h0c000010, 32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("addu_M_beq",   1'b0, 32'h10220019, 32'h0,        32'h00430821, 1'b0, 2'b00, 1'b0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    task automatic test_load_in_m();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("lbu_M_bne",    1'b0, 32'h1422000c, 32'h0,        32'h90210000, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("lbu_M_sub",    1'b0, 32'h00221022, 32'h0,        32'h90210000, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("E_and_M_rt",   1'b0, 32'h00620822, 32'h8c430000, 32'h90220000, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("bne_rt_M",     1'b0, 32'h1441000c, 32'h00a42821, 32'h90210000, 1'b0, 2'b00, 1'b1));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    task automatic test_mult_div();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("mfhi_busy",      1'b0, 32'h00001810, 32'h0,        32'h0, 1'b1, 2'b00, 1'b1));
        q.push_back(mk("mtlo_start",     1'b0, 32'h00600013, 32'h0022001a, 32'h0, 1'b0, 2'b01, 1'b1));
        q.push_back(mk("mflo_idle",      1'b0, 32'h00001012, 32'h0,        32'h0, 1'b0, 2'b00, 1'b0));
        q.push_back(mk("mult_start3",    1'b0, 32'h00220018, 32'h0,        32'h0, 1'b0, 2'b11, 1'b1));
        q.push_back(mk("addu_busy",      1'b0, 32'h00430821, 32'h0,        32'h0, 1'b1, 2'b10, 1'b0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    task automatic test_eret();
        vec_t q[$];
        exp_t e;
        q.push_back(mk("mtc0epc_E_eret",  1'b0, 32'h42000018, 32'h40817000, 32'h0,        1'b0, 2'b00, 1'b1));
        q.push_back(mk("mtc0epc_M_eret",  1'b0, 32'h42000018, 32'h0,        32'h40817000, 1'b0, 2'b00, 1'b1));
        q.push_back(mk("mtc0sr_E_eret",   1'b0, 32'h42000018, 32'h40816000, 32'h0,        1'b0, 2'b00, 1'b0));
        q.push_back(mk("eret_reset",      1'b1, 32'h42000018, 32'h40817000, 32'h0,        1'b0, 2'b00, 1'b0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (bus.Stall !== e.exp) begin
                errors++;
                $display("FAIL %s: Stall=%b expected %b", e.name, bus.Stall, e.exp);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.FD_IR   = 32'h0;
        bus.DE_IR   = 32'h0;
        bus.EM_IR   = 32'h0;
        bus.MW_IR   = 32'h0;
        bus.E_Busy  = 1'b0;
        bus.E_Start = 2'b00;

        test_reset();
        test_load_use();
        test_branch_alu();
        test_load_in_m();
        test_mult_div();
        test_eret();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
